// File: rtl/d_mem_write_buffer.sv
// Posted-store buffer between the CPU MEM stage and D_memory, with youngest-entry load forwarding.
// Optional build macro WBUF_COALESCE_EN: stores to an already-buffered address overwrite it in place.
module d_mem_write_buffer #(
  parameter int WIDTH  = 32,
  parameter int ADDR_W = 32,
  parameter int DEPTH  = 4
) (
  input  logic              clk_i,
  input  logic              rst_i,
  input  logic              mem_write_d,
  input  logic              mem_read_d,
  input  logic [ADDR_W-1:0] addr_d,
  input  logic [WIDTH-1:0]  write_data_d,
  output logic [WIDTH-1:0]  read_data_q,
  output logic              stall_o,
  output logic              mem_write_o,
  output logic              mem_read_o,
  output logic [ADDR_W-1:0] addr_o,
  output logic [WIDTH-1:0]  write_data_o,
  input  logic [WIDTH-1:0]  read_data_i,
  output logic              empty_o
);

  localparam int PTR_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CNT_W = PTR_W + 1;

  if (DEPTH < 2 || (DEPTH & (DEPTH - 1)) != 0) begin : g_bad_depth
    $error("d_mem_write_buffer: DEPTH must be a power of two >= 2");
  end

  logic [ADDR_W-1:0] addr_mem [DEPTH];
  logic [WIDTH-1:0]  data_mem [DEPTH];

  logic [PTR_W-1:0] head_reg, head_next;
  logic [PTR_W-1:0] tail_reg, tail_next;
  logic [CNT_W-1:0] count_reg, count_next;

  logic             load_en;
  logic             drain_en;
  logic             full;
  logic             enq_en;
  logic             coal_hit;
  logic [PTR_W-1:0] coal_idx;
  logic [DEPTH-1:0] valid_vec;
  logic [DEPTH-1:0] match_vec;
  logic             fwd_hit;
  logic [WIDTH-1:0] fwd_data;

  // A simultaneous store suppresses the load, but any asserted read request still blocks draining.
  assign load_en  = mem_read_d & ~mem_write_d;
  assign drain_en = (count_reg != '0) & ~mem_read_d;
  assign full     = (count_reg == CNT_W'(DEPTH));
  assign empty_o  = (count_reg == '0);

  genvar gi;
  generate
    for (gi = 0; gi < DEPTH; gi++) begin : g_entry
      logic [PTR_W-1:0] age;
      assign age           = PTR_W'(gi) - head_reg;
      assign valid_vec[gi] = ({1'b0, age} < count_reg);
      assign match_vec[gi] = valid_vec[gi] & (addr_mem[gi] == addr_d);
    end
  endgenerate

  // Walk from oldest to youngest so the last hit wins.
  always_comb begin
    fwd_hit  = 1'b0;
    fwd_data = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match_vec[head_reg + PTR_W'(k)]) begin
        fwd_hit  = 1'b1;
        fwd_data = data_mem[head_reg + PTR_W'(k)];
      end
    end
  end

`ifdef WBUF_COALESCE_EN
  logic             match_any;
  logic [PTR_W-1:0] match_idx;

  // At most one valid entry per address, so the match vector is one-hot or zero.
  always_comb begin
    match_idx = '0;
    for (int k = 0; k < DEPTH; k++) begin
      if (match_vec[k]) begin
        match_idx = PTR_W'(k);
      end
    end
  end

  assign match_any = |match_vec;
  assign coal_hit  = mem_write_d & match_any & ~(drain_en & (match_idx == head_reg));
  assign coal_idx  = match_idx;
`else
  assign coal_hit  = 1'b0;
  assign coal_idx  = '0;
`endif

  // Full is judged on the registered count; a same-cycle drain does not free a slot.
  assign enq_en  = mem_write_d & ~full & ~coal_hit;
  assign stall_o = mem_write_d & full & ~coal_hit;

  assign head_next  = head_reg + PTR_W'(drain_en);
  assign tail_next  = tail_reg + PTR_W'(enq_en);
  assign count_next = count_reg + CNT_W'(enq_en) - CNT_W'(drain_en);

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      head_reg  <= '0;
      tail_reg  <= '0;
      count_reg <= '0;
    end else begin
      head_reg  <= head_next;
      tail_reg  <= tail_next;
      count_reg <= count_next;
    end
  end

  // Entry storage needs no reset: validity is derived from head and count alone.
  always_ff @(posedge clk_i) begin
    if (enq_en) begin
      addr_mem[tail_reg] <= addr_d;
      data_mem[tail_reg] <= write_data_d;
    end else if (coal_hit) begin
      data_mem[coal_idx] <= write_data_d;
    end
  end

  assign mem_write_o  = drain_en;
  assign mem_read_o   = load_en;
  assign addr_o       = load_en  ? addr_d :
                        drain_en ? addr_mem[head_reg] : '0;
  assign write_data_o = drain_en ? data_mem[head_reg] : '0;
  assign read_data_q  = !load_en ? '0 :
                        fwd_hit  ? fwd_data : read_data_i;

endmodule

// File: tb/tb_d_mem_write_buffer.sv
// Self-checking bench for d_mem_write_buffer: scoreboard of expected D_memory writes plus a memory model.
// Build with WBUF_COALESCE_EN defined to check the coalescing variant.
`timescale 1ns/1ps
module tb_d_mem_write_buffer;

  typedef struct {
    logic [31:0] addr;
    logic [31:0] data;
  } exp_t;

  logic        clk_i = 1'b0;
  logic        rst_i = 1'b1;
  logic        mem_write_d = 1'b0;
  logic        mem_read_d = 1'b0;
  logic [31:0] addr_d = '0;
  logic [31:0] write_data_d = '0;
  logic [31:0] read_data_q;
  logic        stall_o;
  logic        mem_write_o;
  logic        mem_read_o;
  logic [31:0] addr_o;
  logic [31:0] write_data_o;
  logic [31:0] read_data_i;
  logic        empty_o;

  int   n_checks = 0;
  int   n_fail = 0;
  int   wr_pulses = 0;
  exp_t exp_q[$];

  logic [31:0] tb_mem [64];
  bit          mem_ready = 1'b0;

  always #5 clk_i = ~clk_i;

  d_mem_write_buffer #(.WIDTH(32), .ADDR_W(32), .DEPTH(4)) dut (
    .clk_i        (clk_i),
    .rst_i        (rst_i),
    .mem_write_d  (mem_write_d),
    .mem_read_d   (mem_read_d),
    .addr_d       (addr_d),
    .write_data_d (write_data_d),
    .read_data_q  (read_data_q),
    .stall_o      (stall_o),
    .mem_write_o  (mem_write_o),
    .mem_read_o   (mem_read_o),
    .addr_o       (addr_o),
    .write_data_o (write_data_o),
    .read_data_i  (read_data_i),
    .empty_o      (empty_o)
  );

  // D_memory model: preloaded with 1000+index, written on the rising edge.
  assign read_data_i = tb_mem[addr_o[5:0]];

  always @(posedge clk_i) begin
    if (!mem_ready) begin
      for (int i = 0; i < 64; i++) tb_mem[i] <= 32'd1000 + 32'(i);
      mem_ready <= 1'b1;
    end else if (mem_write_o && !rst_i) begin
      tb_mem[addr_o[5:0]] <= write_data_o;
    end
  end

  // Scoreboard: every D_memory write must match the oldest outstanding expected store.
  always @(negedge clk_i) begin
    exp_t e;
    if (!rst_i && mem_write_o) begin
      wr_pulses++;
      n_checks++;
      if (exp_q.size() == 0) begin
        n_fail++;
        $display("FAIL drain_unexpected: addr=%0d data=%0d, required no write", addr_o, write_data_o);
      end else begin
        e = exp_q.pop_front();
        if (addr_o !== e.addr || write_data_o !== e.data) begin
          n_fail++;
          $display("FAIL drain_order: addr=%0d data=%0d, required addr=%0d data=%0d",
                   addr_o, write_data_o, e.addr, e.data);
        end else begin
          $display("drain addr=%0d data=%0d", addr_o, write_data_o);
        end
      end
    end
  end

  task automatic step();
    @(posedge clk_i);
    #1;
  endtask

  task automatic drive(input logic wr, input logic rd, input logic [31:0] a, input logic [31:0] d);
    mem_write_d  = wr;
    mem_read_d   = rd;
    addr_d       = a;
    write_data_d = d;
  endtask

  task automatic push_exp(input logic [31:0] a, input logic [31:0] d);
    exp_t e;
    e.addr = a;
    e.data = d;
    exp_q.push_back(e);
  endtask

  task automatic drain_all(output bit ok);
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    ok = 1'b0;
    for (int c = 0; c < 20; c++) begin
      #1;
      if (empty_o === 1'b1 && exp_q.size() == 0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
  endtask

  task automatic test_reset();
    #2;
    n_checks++;
    if (empty_o !== 1'b1 || stall_o !== 1'b0 || mem_write_o !== 1'b0 || mem_read_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_flags: empty=%b stall=%b mw=%b mr=%b, required 1 0 0 0",
               empty_o, stall_o, mem_write_o, mem_read_o);
    end
    n_checks++;
    if (addr_o !== 32'd0 || write_data_o !== 32'd0 || read_data_q !== 32'd0) begin
      n_fail++;
      $display("FAIL reset_data: addr=%0d wdata=%0d rdata=%0d, required 0 0 0", addr_o, write_data_o, read_data_q);
    end
    repeat (3) @(posedge clk_i);
    #1;
    rst_i = 1'b0;
    #1;
    n_checks++;
    if (empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_release_empty: got %b, required 1", empty_o);
    end
    $display("reset checked");
    step();
  endtask

  task automatic test_reset_mid();
    int wr_before;
    for (int i = 0; i < 3; i++) begin
      drive(1'b1, 1'b1, 32'(10 + i), 32'(100 + i));
      push_exp(32'(10 + i), 32'(100 + i));
      step();
    end
    drive(1'b0, 1'b1, 32'd60, 32'd0);
    #1;
    n_checks++;
    if (empty_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_queued: empty=%b, required 0", empty_o);
    end
    rst_i = 1'b1;
    exp_q.delete();
    wr_before = wr_pulses;
    drive(1'b1, 1'b1, 32'd12, 32'd55);
    #1;
    n_checks++;
    if (empty_o !== 1'b1 || stall_o !== 1'b0 || mem_write_o !== 1'b0) begin
      n_fail++;
      $display("FAIL reset_mid_flags: empty=%b stall=%b mw=%b, required 1 0 0", empty_o, stall_o, mem_write_o);
    end
    step();
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    step();
    rst_i = 1'b0;
    repeat (4) step();
    n_checks++;
    if (wr_pulses !== wr_before || empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL reset_mid_no_write: writes=%0d empty=%b, required 0 1", wr_pulses - wr_before, empty_o);
    end
    $display("reset mid-operation checked");
  endtask

  task automatic test_back_to_back();
    logic [31:0] a_tab [4];
    logic [31:0] d_tab [4];
    bit ok;
    a_tab = '{32'd20, 32'd21, 32'd22, 32'd23};
    d_tab = '{32'd5, 32'd3, 32'd9, 32'd1};
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b0, a_tab[i], d_tab[i]);
      #1;
      n_checks++;
      if (mem_write_o !== (i != 0) || stall_o !== 1'b0) begin
        n_fail++;
        $display("FAIL b2b_mw[%0d]: mw=%b stall=%b, required %b 0", i, mem_write_o, stall_o, (i != 0));
      end
      push_exp(a_tab[i], d_tab[i]);
      step();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    n_checks++;
    if (mem_write_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_last_drain: mw=%b, required 1", mem_write_o);
    end
    step();
    n_checks++;
    if (mem_write_o !== 1'b0 || empty_o !== 1'b1) begin
      n_fail++;
      $display("FAIL b2b_idle: mw=%b empty=%b, required 0 1", mem_write_o, empty_o);
    end
    for (int i = 0; i < 4; i++) begin
      n_checks++;
      if (tb_mem[20 + i] !== d_tab[i]) begin
        n_fail++;
        $display("FAIL b2b_mem[%0d]: got %0d, required %0d", 20 + i, tb_mem[20 + i], d_tab[i]);
      end
    end
    drain_all(ok);
    $display("back-to-back stores checked");
  endtask

  task automatic test_full_stall();
    bit ok;
    for (int i = 0; i < 5; i++) begin
      drive(1'b1, 1'b1, 32'(30 + i), 32'(i + 1));
      #1;
      n_checks++;
      if (stall_o !== (i == 4) || mem_read_o !== 1'b0) begin
        n_fail++;
        $display("FAIL full_stall[%0d]: stall=%b mr=%b, required %b 0", i, stall_o, mem_read_o, (i == 4));
      end
      if (i != 4) push_exp(32'(30 + i), 32'(i + 1));
      step();
      drive(1'b0, 1'b1, 32'd30, 32'd0);
      #1;
      n_checks++;
      if (read_data_q !== 32'd1 || mem_write_o !== 1'b0) begin
        n_fail++;
        $display("FAIL full_fwd[%0d]: rdata=%0d mw=%b, required 1 0", i, read_data_q, mem_write_o);
      end
      step();
    end
    drive(1'b0, 1'b0, 32'd0, 32'd0);
    #1;
    n_checks++;
    if (mem_write_o !== 1'b1 || addr_o !== 32'd30) begin
      n_fail++;
      $display("FAIL full_release_drain: mw=%b addr=%0d, required 1 30", mem_write_o, addr_o);
    end
    step();
    drive(1'b1, 1'b1, 32'd34, 32'd5);
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL full_retry: stall=%b, required 0", stall_o);
    end
    push_exp(32'd34, 32'd5);
    step();
    drain_all(ok);
    n_checks++;
    if (!ok || tb_mem[34] !== 32'd5 || tb_mem[30] !== 32'd1) begin
      n_fail++;
      $display("FAIL full_final: ok=%b mem30=%0d mem34=%0d, required 1 1 5", ok, tb_mem[30], tb_mem[34]);
    end
    $display("full-buffer stall checked");
  endtask

  task automatic test_forward();
    bit ok;
    drive(1'b1, 1'b0, 32'd21, 32'd7);
    push_exp(32'd21, 32'd7);
    step();
    drive(1'b0, 1'b1, 32'd21, 32'd0);
    #1;
    n_checks++;
    if (read_data_q !== 32'd7 || tb_mem[21] !== 32'd3) begin
      n_fail++;
      $display("FAIL fwd_hit: rdata=%0d mem21=%0d, required 7 3", read_data_q, tb_mem[21]);
    end
    n_checks++;
    if (mem_read_o !== 1'b1 || addr_o !== 32'd21 || mem_write_o !== 1'b0) begin
      n_fail++;
      $display("FAIL fwd_port: mr=%b addr=%0d mw=%b, required 1 21 0", mem_read_o, addr_o, mem_write_o);
    end
    step();
    drive(1'b0, 1'b1, 32'd50, 32'd0);
    #1;
    n_checks++;
    if (read_data_q !== 32'd1050) begin
      n_fail++;
      $display("FAIL fwd_miss: rdata=%0d, required 1050", read_data_q);
    end
    step();
    drain_all(ok);
    n_checks++;
    if (!ok || tb_mem[21] !== 32'd7) begin
      n_fail++;
      $display("FAIL fwd_final: ok=%b mem21=%0d, required 1 7", ok, tb_mem[21]);
    end
    $display("load forwarding checked");
  endtask

  task automatic test_same_addr();
    bit ok;
    int wr_before;
    int exp_pulses;
    wr_before = wr_pulses;
    drive(1'b1, 1'b1, 32'd22, 32'd1);
    push_exp(32'd22, 32'd1);
    step();
    drive(1'b1, 1'b1, 32'd22, 32'd2);
    #1;
    n_checks++;
    if (stall_o !== 1'b0) begin
      n_fail++;
      $display("FAIL same_addr_stall: stall=%b, required 0", stall_o);
    end
`ifdef WBUF_COALESCE_EN
    foreach (exp_q[k]) if (exp_q[k].addr == 32'd22) exp_q[k].data = 32'd2;
    exp_pulses = 1;
`else
    push_exp(32'd22, 32'd2);
    exp_pulses = 2;
`endif
    step();
    drive(1'b0, 1'b1, 32'd22, 32'd0);
    #1;
    n_checks++;
    if (read_data_q !== 32'd2) begin
      n_fail++;
      $display("FAIL same_addr_fwd: rdata=%0d, required 2", read_data_q);
    end
    step();
    drain_all(ok);
    n_checks++;
    if (!ok || (wr_pulses - wr_before) != exp_pulses || tb_mem[22] !== 32'd2) begin
      n_fail++;
      $display("FAIL same_addr_final: ok=%b writes=%0d mem22=%0d, required 1 %0d 2",
               ok, wr_pulses - wr_before, tb_mem[22], exp_pulses);
    end
    $display("same-address stores checked");
  endtask

  task automatic test_store_load_full();
    bit ok;
    for (int i = 0; i < 4; i++) begin
      drive(1'b1, 1'b1, 32'(40 + i), 32'(64 + i));
      push_exp(32'(40 + i), 32'(64 + i));
      step();
    end
    drive(1'b1, 1'b1, 32'd44, 32'd9);
    #1;
    n_checks++;
    if (stall_o !== 1'b1 || mem_read_o !== 1'b0 || mem_write_o !== 1'b0 || read_data_q !== 32'd0) begin
      n_fail++;
      $display("FAIL st_ld_full: stall=%b mr=%b mw=%b rdata=%0d, required 1 0 0 0",
               stall_o, mem_read_o, mem_write_o, read_data_q);
    end
    step();
    drain_all(ok);
    n_checks++;
    if (!ok || tb_mem[44] !== 32'd1044 || tb_mem[43] !== 32'd67) begin
      n_fail++;
      $display("FAIL st_ld_full_final: ok=%b mem44=%0d mem43=%0d, required 1 1044 67", ok, tb_mem[44], tb_mem[43]);
    end
    $display("store+load on full buffer checked");
  endtask

  initial begin
    test_reset();
    test_reset_mid();
    test_back_to_back();
    test_full_stall();
    test_forward();
    test_same_addr();
    test_store_load_full();
    n_checks++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL leftover_expected: %0d stores never written, required 0", exp_q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached, required completion");
    $fatal(1, "watchdog expired");
  end

endmodule
